// File: rtl/rom_access_ctrl_if.sv
// Client and memory-port signal bundle for rom_access_ctrl.
// The slave side is the controller; the master side is the clients plus the memory macro.
interface rom_access_ctrl_if #(
    parameter int DW = 2,
    parameter int AW = 2
);
    logic          init_req;
    logic          req0;
    logic          req1;
    logic          we0;
    logic          we1;
    logic [AW-1:0] addr0;
    logic [AW-1:0] addr1;
    logic [DW-1:0] wdata0;
    logic [DW-1:0] wdata1;
    logic          gnt0;
    logic          gnt1;
    logic          rvalid0;
    logic          rvalid1;
    logic [DW-1:0] rdata0;
    logic [DW-1:0] rdata1;
    logic          busy;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  init_req, req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
        output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, busy, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output init_req, req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, busy, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/rom_access_ctrl.sv
// Fills the lookup memory with entry==address, then round-robins one access per cycle between two clients.
// Grant is same-cycle, read data one cycle later; a losing requester simply holds its request.
module rom_access_ctrl #(
    parameter int DW = 2,
    parameter int AW = 2
) (
    input  logic               clk,
    input  logic               reset,
    rom_access_ctrl_if.slave   bus
);
    typedef enum logic {INIT, RUN} state_t;

    localparam logic [AW-1:0] LAST_ADDR = '1;

    state_t        state, state_nxt;
    logic [AW-1:0] init_cnt, init_cnt_nxt;
    logic          last, last_nxt;
    logic          rd_pend0, rd_pend1;
    logic          gnt0_c, gnt1_c;
    logic          busy_c;
    logic          mem_we_c;
    logic [AW-1:0] mem_addr_c;
    logic [DW-1:0] mem_wdata_c;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= INIT;
            init_cnt <= '0;
            last     <= 1'b1;
            rd_pend0 <= 1'b0;
            rd_pend1 <= 1'b0;
        end else begin
            state    <= state_nxt;
            init_cnt <= init_cnt_nxt;
            last     <= last_nxt;
            rd_pend0 <= gnt0_c & ~bus.we0;
            rd_pend1 <= gnt1_c & ~bus.we1;
        end
    end

    always_comb begin
        state_nxt    = state;
        init_cnt_nxt = init_cnt;
        last_nxt     = last;
        gnt0_c       = 1'b0;
        gnt1_c       = 1'b0;
        busy_c       = 1'b0;
        mem_we_c     = 1'b0;
        mem_addr_c   = '0;
        mem_wdata_c  = '0;
        case (state)
            INIT: begin
                busy_c       = 1'b1;
                mem_we_c     = 1'b1;
                mem_addr_c   = init_cnt;
                mem_wdata_c  = DW'(init_cnt);
                init_cnt_nxt = init_cnt + AW'(1);
                if (init_cnt == LAST_ADDR) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (bus.init_req) begin
                    state_nxt    = INIT;
                    init_cnt_nxt = '0;
                end else if (bus.req0 && (!bus.req1 || last)) begin
                    // Under contention the requester that did not win last time goes first.
                    gnt0_c      = 1'b1;
                    last_nxt    = 1'b0;
                    mem_we_c    = bus.we0;
                    mem_addr_c  = bus.addr0;
                    mem_wdata_c = bus.wdata0;
                end else if (bus.req1) begin
                    gnt1_c      = 1'b1;
                    last_nxt    = 1'b1;
                    mem_we_c    = bus.we1;
                    mem_addr_c  = bus.addr1;
                    mem_wdata_c = bus.wdata1;
                end
            end
            default: state_nxt = INIT;
        endcase
        // While reset is held every output sits at its reset value, so no write or grant leaks out.
        if (!reset) begin
            gnt0_c      = 1'b0;
            gnt1_c      = 1'b0;
            busy_c      = 1'b1;
            mem_we_c    = 1'b0;
            mem_addr_c  = '0;
            mem_wdata_c = '0;
        end
    end

    assign bus.gnt0      = gnt0_c;
    assign bus.gnt1      = gnt1_c;
    assign bus.busy      = busy_c;
    assign bus.mem_we    = mem_we_c;
    assign bus.mem_addr  = mem_addr_c;
    assign bus.mem_wdata = mem_wdata_c;
    assign bus.rvalid0   = rd_pend0 & reset;
    assign bus.rvalid1   = rd_pend1 & reset;
    assign bus.rdata0    = bus.rvalid0 ? bus.mem_rdata : '0;
    assign bus.rdata1    = bus.rvalid1 ? bus.mem_rdata : '0;
endmodule

// File: tb/tb_rom_access_ctrl.sv
// Directed bench for rom_access_ctrl with a registered-read memory model on the mem_* port.
module tb_rom_access_ctrl;
    logic clk;
    logic reset;
    int   checks;
    int   failures;

    rom_access_ctrl_if #(.DW(2), .AW(2)) bus ();

    rom_access_ctrl #(.DW(2), .AW(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory macro: writes land at the edge, read data appears the cycle after the address.
    logic [1:0] mem [4];
    logic [1:0] rdq;
    always @(posedge clk) begin
        if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
        rdq <= mem[bus.mem_addr];
    end
    assign bus.mem_rdata = rdq;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic init_phase(input string tag);
        for (int i = 0; i < 4; i++) begin
            if (i != 0) @(negedge clk);
            #1;
            check({tag, "_busy"}, bus.busy, 1);
            check({tag, "_we"}, bus.mem_we, 1);
            check({tag, "_addr"}, bus.mem_addr, i);
            check({tag, "_wdata"}, bus.mem_wdata, i);
            check({tag, "_nognt"}, bus.gnt0 | bus.gnt1, 0);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        reset = 1'b0;
        bus.init_req = 1'b0;
        bus.req0 = 1'b0; bus.we0 = 1'b0; bus.addr0 = '0; bus.wdata0 = '0;
        bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = '0; bus.wdata1 = '0;

        // Reset held for two cycles.
        @(negedge clk); #1;
        check("rst_busy", bus.busy, 1);
        check("rst_mem_we", bus.mem_we, 0);
        check("rst_gnt0", bus.gnt0, 0);
        check("rst_rvalid0", bus.rvalid0, 0);
        check("rst_rdata1", bus.rdata1, 0);
        @(negedge clk);
        reset = 1'b1;
        bus.req1 = 1'b1;
        init_phase("init");

        // Single read of addr 2.
        @(negedge clk);
        bus.req1 = 1'b0;
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 2'd2;
        #1;
        check("rd_busy", bus.busy, 0);
        check("rd_gnt0", bus.gnt0, 1);
        check("rd_gnt1", bus.gnt1, 0);
        check("rd_mem_addr", bus.mem_addr, 2);
        check("rd_mem_we", bus.mem_we, 0);
        @(negedge clk);
        bus.req0 = 1'b0;
        #1;
        check("rd_rvalid0", bus.rvalid0, 1);
        check("rd_rdata0", bus.rdata0, 2);
        check("rd_rvalid1", bus.rvalid1, 0);
        check("idle_mem_addr", bus.mem_addr, 0);

        // Solo read by requester 1 leaves last=1, so requester 0 wins first contention.
        @(negedge clk);
        bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 2'd1;
        #1;
        check("solo1_gnt1", bus.gnt1, 1);
        check("solo1_gnt0", bus.gnt0, 0);
        check("solo1_rvalid0", bus.rvalid0, 0);

        // Contention: 0,1,0,1.
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            bus.req0 = 1'b1; bus.addr0 = 2'd2;
            bus.req1 = 1'b1; bus.addr1 = 2'd3;
            #1;
            check($sformatf("ct%0d_gnt0", k), bus.gnt0, (k % 2 == 0) ? 1 : 0);
            check($sformatf("ct%0d_gnt1", k), bus.gnt1, (k % 2 == 1) ? 1 : 0);
            check($sformatf("ct%0d_addr", k), bus.mem_addr, (k % 2 == 0) ? 2 : 3);
            if (k % 2 == 0) begin
                check($sformatf("ct%0d_rvalid1", k), bus.rvalid1, 1);
                check($sformatf("ct%0d_rdata1", k), bus.rdata1, (k == 0) ? 1 : 3);
                check($sformatf("ct%0d_rvalid0", k), bus.rvalid0, 0);
            end else begin
                check($sformatf("ct%0d_rvalid0", k), bus.rvalid0, 1);
                check($sformatf("ct%0d_rdata0", k), bus.rdata0, 2);
                check($sformatf("ct%0d_rvalid1", k), bus.rvalid1, 0);
            end
        end

        // Write 0 to addr 3 by requester 1 (last contention read still returns).
        @(negedge clk);
        bus.req0 = 1'b0;
        bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 2'd3; bus.wdata1 = 2'd0;
        #1;
        check("wr_rvalid1", bus.rvalid1, 1);
        check("wr_rdata1", bus.rdata1, 3);
        check("wr_gnt1", bus.gnt1, 1);
        check("wr_mem_we", bus.mem_we, 1);
        check("wr_mem_addr", bus.mem_addr, 3);
        check("wr_mem_wdata", bus.mem_wdata, 0);
        @(negedge clk);
        bus.we1 = 1'b0;
        #1;
        check("raw_gnt1", bus.gnt1, 1);
        check("raw_mem_we", bus.mem_we, 0);
        check("raw_no_wr_rvalid", bus.rvalid1, 0);

        // init_req while req0 is high; the pending read still completes.
        @(negedge clk);
        bus.req1 = 1'b0;
        bus.init_req = 1'b1;
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 2'd3;
        #1;
        check("raw_rvalid1", bus.rvalid1, 1);
        check("raw_rdata1", bus.rdata1, 0);
        check("ireq_gnt0", bus.gnt0, 0);
        check("ireq_mem_we", bus.mem_we, 0);
        check("ireq_busy", bus.busy, 0);
        @(negedge clk);
        bus.init_req = 1'b0;
        init_phase("reinit");
        @(negedge clk); #1;
        check("post_busy", bus.busy, 0);
        check("post_gnt0", bus.gnt0, 1);
        @(negedge clk);
        bus.req0 = 1'b0;
        bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 2'd2;
        #1;
        check("post_rvalid0", bus.rvalid0, 1);
        check("post_rdata0", bus.rdata0, 3);
        check("mid_gnt1", bus.gnt1, 1);

        // Reset right after a read grant suppresses its rvalid.
        @(negedge clk);
        bus.req1 = 1'b0;
        reset = 1'b0;
        #1;
        check("mid_rvalid1", bus.rvalid1, 0);
        check("mid_rdata1", bus.rdata1, 0);
        check("mid_busy", bus.busy, 1);
        check("mid_mem_we", bus.mem_we, 0);
        @(negedge clk); #1;
        check("mid2_rvalid1", bus.rvalid1, 0);
        check("mid2_busy", bus.busy, 1);
        @(negedge clk);
        reset = 1'b1;
        init_phase("rstinit");
        @(negedge clk); #1;
        check("end_busy", bus.busy, 0);
        check("end_mem_we", bus.mem_we, 0);
        check("end_gnt", bus.gnt0 | bus.gnt1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/rom_access_ctrl.md
# rom_access_ctrl

Sequencing and arbitration controller for the team's small 2-bit-wide lookup memory. After reset it fills every entry with its own address value, then shares the single memory port between two requesters using round-robin arbitration, one access per cycle. Sits between the memory macro and its two clients; the memory itself is external to this block.

## Interface

**Parameters**
- `DW`, 2, data width of memory entries.
- `AW`, 2, address width; memory depth is 2^AW.

**Ports**
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-low reset, sampled on `clk`.
- `init_req`  in  1  single-cycle pulse that requests re-initialisation of the memory; honoured only in RUN.
- `req0` / `req1`  in  1  access request from requester 0 / 1.
- `we0` / `we1`  in  1  1 = write, 0 = read. Qualified by `req`.
- `addr0` / `addr1`  in  AW  access address.
- `wdata0` / `wdata1`  in  DW  write data.
- `gnt0` / `gnt1`  out  1  grant; the access is performed in this cycle.
- `rvalid0` / `rvalid1`  out  1  read data valid.
- `rdata0` / `rdata1`  out  DW  read data; 0 when the matching `rvalid` is low.
- `busy`  out  1  high while initialising.
- `mem_we`  out  1  memory write enable.
- `mem_addr`  out  AW  memory address.
- `mem_wdata`  out  DW  memory write data.
- `mem_rdata`  in  DW  memory read data, valid one cycle after a read address is presented.

## Operation

- **States:** INIT, RUN.
- **Reset** (`reset`=0 at a rising edge):
  - state → INIT, `init_cnt` = 0, `last` = 1 (so requester 0 wins the first contention).
  - Pending read-valid flags cleared.
  - All outputs 0 except `busy` = 1.
- **INIT:**
  - Each cycle drives `mem_we`=1, `mem_addr`=`init_cnt`, `mem_wdata`=`init_cnt` zero-extended or truncated to DW. `init_cnt` then increments.
  - After writing entry 2^AW−1, `init_cnt` wraps to 0 and the state moves to RUN.
  - `busy`=1 and `gnt0`=`gnt1`=0 throughout. Requests are ignored, not queued.
- **RUN:**
  - `busy`=0.
  - Grants are combinational from the current `req` and `last`:
    - only `req0` → `gnt0`
    - only `req1` → `gnt1`
    - both → the requester ≠ `last`.
  - On a grant, `last` ← the granted index.
  - The memory port is driven from the granted requester: `mem_we`=`weN`, `mem_addr`=`addrN`, `mem_wdata`=`wdataN`.
  - With no grant, all `mem_*` outputs are 0.
- **init_req in RUN:**
  - Takes priority over both requesters: no grant in that cycle, `mem_we`=0.
  - Next state is INIT, with `init_cnt`=0.
  - `last` is unchanged.
  - A read granted in the previous cycle still completes its `rvalid`.
  - `init_req` is ignored while in INIT.
- **Requester rules:**
  - Hold `req`/`we`/`addr`/`wdata` stable until the cycle in which `gnt` is high.
  - `req` may drop without a grant.
  - Back-to-back grants to the same requester are legal when the other requester is idle.
- **Read return:**
  - A read granted in cycle N gives `rvalidN`=1 and `rdataN`=`mem_rdata` in cycle N+1.
  - The other requester's `rvalid` stays 0.
- **Write return:** writes produce no `rvalid`.

## Timing

- Init duration: exactly 2^AW cycles after reset is released (4 cycles at the defaults). The first grant is possible in the cycle after the last init write.
- Grant latency: 0 cycles (same cycle as `req` in RUN).
- Read latency: 1 cycle (grant → `rvalid`).
- Throughput: one access per cycle.
- Read-after-write to the same address:
  - write granted in cycle N, read granted in cycle N+1 → new data in cycle N+2.
  - This relies on the memory's write-then-read ordering across cycles.
- Reset asserted mid-operation: outputs return to their reset values at the next edge, and any in-flight `rvalid` due that cycle is suppressed.

## Test plan

1. **Reset and init.** Hold `reset`=0 for 2 cycles, then release. Expect `busy`=1 for 4 cycles, with `mem_we`=1 and addr/data pairs 0/0, 1/1, 2/2, 3/3. Then `busy`=0.
2. **Single read.** After init, `req0`=1, `we0`=0, `addr0`=2. Expect `gnt0`=1 the same cycle and `rvalid0`=1, `rdata0`=2 the next cycle, with `rvalid1`=0.
3. **Contention.** `req0` and `req1` held high for 4 cycles, both reads. Expect grants in the order 0, 1, 0, 1, and each `rvalid` one cycle after its grant.
4. **Write then read.** `req1` writes 2'b00 to addr 3. The following cycle `req1` reads addr 3. Expect `mem_we`=1 on the write cycle and `rdata1`=0 one cycle after the read grant.
5. **Re-init during access.** `init_req` pulsed while `req0` is high. Expect no grant that cycle and `busy`=1 for the next 4 cycles. Afterwards a read of addr 3 returns 3.
6. **Reset mid-read.** Grant a read to `req1`, then drive `reset`=0 on the next edge. Expect `rvalid1`=0 and re-initialisation once reset is released.
